// File: rtl/l1_cache_pkg.sv
`default_nettype none
// ============================================================================
// Module      : l1_cache_pkg
// Description : Shared constants, the fill-entry record and the refill FSM
//               state encoding for the L1 refill path.
// Revision    : 1.0 - initial release
// ============================================================================
package l1_cache_pkg;

    localparam int ADDR_W     = 16;
    localparam int INDEX_W    = 6;
    localparam int OFFSET_W   = 3;
    localparam int LINE_BYTES = 2 ** OFFSET_W;
    localparam int TAG_W      = ADDR_W - INDEX_W - OFFSET_W;

    // Word written into the tag/data arrays; line byte k sits at [8k+7:8k].
    typedef struct packed {
        logic                        valid;
        logic [TAG_W-1:0]            tag;
        logic [8*LINE_BYTES-1:0]     line;
    } fill_entry_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_RECV  = 2'd2,
        ST_WRITE = 2'd3
    } refill_state_t;

endpackage
`default_nettype wire

// File: rtl/l1_line_assembler.sv
`default_nettype none
// ============================================================================
// Module      : l1_line_assembler
// Description : Collects one response byte per accepted beat into a line
//               register. The beat counter selects the byte lane.
// Ports       : clk, rst_n      clock / async active-low reset
//               beat_valid      byte on beat_data is to be stored
//               beat_data       response byte
//               clear           rewind the beat counter for the next line
//               line            assembled line, byte k at [8k+7:8k]
//               last_beat       current beat completes the line
// Revision    : 1.0 - initial release
// ============================================================================
module l1_line_assembler #(
    parameter int NBYTES = l1_cache_pkg::LINE_BYTES,
    parameter int CNT_W  = $clog2(NBYTES)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  beat_valid,
    input  logic [7:0]            beat_data,
    input  logic                  clear,
    output logic [8*NBYTES-1:0]   line,
    output logic                  last_beat
);
    import l1_cache_pkg::*;

    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [8*NBYTES-1:0] line_q, line_d;

    always_comb begin
        cnt_d  = cnt_q;
        line_d = line_q;
        if (clear) begin
            // Stale lanes are left in place: every lane is rewritten by the next line.
            cnt_d = '0;
        end else if (beat_valid) begin
            line_d[8*cnt_q +: 8] = beat_data;
            cnt_d                = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            line_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            line_q <= line_d;
        end
    end

    assign line      = line_q;
    assign last_beat = beat_valid && (cnt_q == CNT_W'(NBYTES - 1));

endmodule
`default_nettype wire

// File: rtl/l1_refill_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : l1_refill_ctrl
// Description : L1 miss handler. Arbitrates I/D line misses, reads the line
//               from next-level memory one byte per beat, and writes
//               {valid, tag, line} into the victim way of the missing set.
// Ports       : clk, rst_n                 clock / async active-low reset
//               i_miss_req/addr/ack        I-side miss handshake
//               d_miss_req/addr/ack        D-side miss handshake
//               mem_req_valid/ready/addr   line read request
//               mem_rsp_valid/data         one response byte per beat
//               fill_we/is_inst/way/index  cache array write strobe + target
//               fill_entry                 {valid, tag, line}
//               busy                       refill in progress
// Revision    : 1.0 - initial release
// ============================================================================
module l1_refill_ctrl #(
    parameter int ADDR_W   = l1_cache_pkg::ADDR_W,
    parameter int INDEX_W  = l1_cache_pkg::INDEX_W,
    parameter int OFFSET_W = l1_cache_pkg::OFFSET_W
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_miss_req,
    input  logic [ADDR_W-1:0]   i_miss_addr,
    output logic                i_miss_ack,
    input  logic                d_miss_req,
    input  logic [ADDR_W-1:0]   d_miss_addr,
    output logic                d_miss_ack,
    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic [ADDR_W-1:0]   mem_req_addr,
    input  logic                mem_rsp_valid,
    input  logic [7:0]          mem_rsp_data,
    output logic                fill_we,
    output logic                fill_is_inst,
    output logic                fill_way,
    output logic [INDEX_W-1:0]  fill_index,
    output logic [ADDR_W-INDEX_W-OFFSET_W+8*(2**OFFSET_W):0] fill_entry,
    output logic                busy
);
    import l1_cache_pkg::*;

    localparam int LINE_BYTES = 2 ** OFFSET_W;
    localparam int TAG_W      = ADDR_W - INDEX_W - OFFSET_W;
    localparam int SETS       = 2 ** INDEX_W;
    localparam logic [ADDR_W-1:0] OFFSET_MASK = ADDR_W'(LINE_BYTES - 1);

    refill_state_t       state_q, state_d;
    logic                is_inst_q, is_inst_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                way_q, way_d;
    logic                last_inst_q, last_inst_d;
    logic [SETS-1:0]     vic_i_q, vic_i_d;
    logic [SETS-1:0]     vic_d_q, vic_d_d;
    logic                mem_req_valid_q, mem_req_valid_d;
    logic                fill_we_q, fill_we_d;
    logic                i_ack_q, i_ack_d;
    logic                d_ack_q, d_ack_d;
    logic                busy_q, busy_d;

    logic                    w_pick_inst;
    logic [ADDR_W-1:0]       w_sel_addr;
    logic [INDEX_W-1:0]      w_sel_index;
    logic [INDEX_W-1:0]      w_cur_index;
    logic                    w_beat_valid;
    logic                    w_last_beat;
    logic [8*LINE_BYTES-1:0] w_line;

    // A lone request always wins; on a tie the side not serviced last goes.
    assign w_pick_inst  = i_miss_req && (!d_miss_req || !last_inst_q);
    assign w_sel_addr   = w_pick_inst ? i_miss_addr : d_miss_addr;
    assign w_sel_index  = w_sel_addr[OFFSET_W +: INDEX_W];
    assign w_cur_index  = addr_q[OFFSET_W +: INDEX_W];
    // Response bytes only count once the request handshake has completed.
    assign w_beat_valid = mem_rsp_valid && (state_q == ST_RECV);

    l1_line_assembler #(
        .NBYTES (LINE_BYTES)
    ) u_asm (
        .clk        (clk),
        .rst_n      (rst_n),
        .beat_valid (w_beat_valid),
        .beat_data  (mem_rsp_data),
        .clear      (state_q == ST_WRITE),
        .line       (w_line),
        .last_beat  (w_last_beat)
    );

    always_comb begin
        state_d         = state_q;
        is_inst_d       = is_inst_q;
        addr_d          = addr_q;
        way_d           = way_q;
        last_inst_d     = last_inst_q;
        vic_i_d         = vic_i_q;
        vic_d_d         = vic_d_q;
        mem_req_valid_d = mem_req_valid_q;
        fill_we_d       = 1'b0;
        i_ack_d         = 1'b0;
        d_ack_d         = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_miss_req || d_miss_req) begin
                    state_d         = ST_REQ;
                    is_inst_d       = w_pick_inst;
                    last_inst_d     = w_pick_inst;
                    addr_d          = w_sel_addr;
                    way_d           = w_pick_inst ? vic_i_q[w_sel_index] : vic_d_q[w_sel_index];
                    mem_req_valid_d = 1'b1;
                end
            end
            ST_REQ: begin
                if (mem_req_ready) begin
                    state_d         = ST_RECV;
                    mem_req_valid_d = 1'b0;
                end
            end
            ST_RECV: begin
                if (w_last_beat) begin
                    state_d   = ST_WRITE;
                    fill_we_d = 1'b1;
                    i_ack_d   = is_inst_q;
                    d_ack_d   = !is_inst_q;
                end
            end
            ST_WRITE: begin
                state_d = ST_IDLE;
                if (is_inst_q) vic_i_d[w_cur_index] = !vic_i_q[w_cur_index];
                else           vic_d_d[w_cur_index] = !vic_d_q[w_cur_index];
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= ST_IDLE;
            is_inst_q       <= 1'b0;
            addr_q          <= '0;
            way_q           <= 1'b0;
            last_inst_q     <= 1'b0;   // D counts as last serviced, so I wins the first tie
            vic_i_q         <= '0;
            vic_d_q         <= '0;
            mem_req_valid_q <= 1'b0;
            fill_we_q       <= 1'b0;
            i_ack_q         <= 1'b0;
            d_ack_q         <= 1'b0;
            busy_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            is_inst_q       <= is_inst_d;
            addr_q          <= addr_d;
            way_q           <= way_d;
            last_inst_q     <= last_inst_d;
            vic_i_q         <= vic_i_d;
            vic_d_q         <= vic_d_d;
            mem_req_valid_q <= mem_req_valid_d;
            fill_we_q       <= fill_we_d;
            i_ack_q         <= i_ack_d;
            d_ack_q         <= d_ack_d;
            busy_q          <= busy_d;
        end
    end

    assign mem_req_valid = mem_req_valid_q;
    assign mem_req_addr  = addr_q & ~OFFSET_MASK;
    assign i_miss_ack    = i_ack_q;
    assign d_miss_ack    = d_ack_q;
    assign fill_we       = fill_we_q;
    assign fill_is_inst  = is_inst_q;
    assign fill_way      = way_q;
    assign fill_index    = w_cur_index;
    // Valid bit follows the strobe so the entry bus is all-zero out of reset.
    assign fill_entry    = {fill_we_q, addr_q[ADDR_W-1 -: TAG_W], w_line};
    assign busy          = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_l1_refill_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_l1_refill_ctrl
// Description : Self-checking bench for l1_refill_ctrl: directed table,
//               multi-cycle corner sequences and randomized transactions
//               checked against a transaction-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_l1_refill_ctrl;
    import l1_cache_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_miss_req = 1'b0, d_miss_req = 1'b0;
    logic [15:0] i_miss_addr = '0, d_miss_addr = '0;
    logic        i_miss_ack, d_miss_ack;
    logic        mem_req_valid;
    logic        mem_req_ready = 1'b0;
    logic [15:0] mem_req_addr;
    logic        mem_rsp_valid = 1'b0;
    logic [7:0]  mem_rsp_data = '0;
    logic        fill_we, fill_is_inst, fill_way, busy;
    logic [5:0]  fill_index;
    logic [71:0] fill_entry;

    always #5 clk = ~clk;

    l1_refill_ctrl dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_miss_req    (i_miss_req),
        .i_miss_addr   (i_miss_addr),
        .i_miss_ack    (i_miss_ack),
        .d_miss_req    (d_miss_req),
        .d_miss_addr   (d_miss_addr),
        .d_miss_ack    (d_miss_ack),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_req_addr  (mem_req_addr),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rsp_data  (mem_rsp_data),
        .fill_we       (fill_we),
        .fill_is_inst  (fill_is_inst),
        .fill_way      (fill_way),
        .fill_index    (fill_index),
        .fill_entry    (fill_entry),
        .busy          (busy)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state: next victim per side and set, last side serviced.
    bit mvic_i[64];
    bit mvic_d[64];
    bit mlast_inst;

    // Values captured at the last fill, for the directed table.
    bit          cap_way;
    logic [5:0]  cap_idx;
    logic [6:0]  cap_tag;
    logic [15:0] cap_req;

    typedef struct {
        bit          is_inst;
        logic [15:0] addr;
        logic [7:0]  base;
        bit          exp_way;
        logic [5:0]  exp_idx;
        logic [6:0]  exp_tag;
        logic [15:0] exp_req;
        int          exp_lat;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 64; i++) begin
            mvic_i[i] = 1'b0;
            mvic_d[i] = 1'b0;
        end
        mlast_inst = 1'b0;
    endtask

    // Serves one refill for the side the model expects, returning the number
    // of cycles from the first tick until the fill strobe is observed.
    task automatic serve(input bit exp_inst, input logic [15:0] a, input int rdelay,
                         input int bmode, input bit junk, input bit rnd,
                         input logic [7:0] base, output int lat);
        int          t;
        bit          ok;
        bit          bub;
        bit          exp_way;
        fill_entry_t e;
        logic [63:0] exp_line;
        logic [7:0]  byt;
        logic [5:0]  idx;
        logic [6:0]  tag;
        idx     = a[8:3];
        tag     = a[15:9];
        exp_way = exp_inst ? mvic_i[idx] : mvic_d[idx];
        t  = 0;
        ok = 1'b0;
        for (int w = 0; w < 30 && !ok; w++) begin
            if (junk) begin
                mem_rsp_valid = 1'($urandom_range(0, 1));
                mem_rsp_data  = 8'($urandom);
            end
            tick();
            t++;
            ok = (mem_req_valid === 1'b1);
        end
        chk("req_valid_seen", 128'(ok), 128'd1);
        if (!ok) begin
            i_miss_req = 1'b0;
            d_miss_req = 1'b0;
            lat = -1;
            return;
        end
        chk("req_addr", 128'(mem_req_addr), 128'({a[15:3], 3'b000}));
        for (int r = 0; r < rdelay; r++) begin
            mem_req_ready = 1'b0;
            if (junk) begin
                mem_rsp_valid = 1'($urandom_range(0, 1));
                mem_rsp_data  = 8'($urandom);
            end
            tick();
            t++;
            chk("req_hold_valid", 128'(mem_req_valid), 128'd1);
            chk("req_hold_addr", 128'(mem_req_addr), 128'({a[15:3], 3'b000}));
        end
        mem_req_ready = 1'b1;
        if (junk) begin
            mem_rsp_valid = 1'b1;
            mem_rsp_data  = 8'($urandom);
        end
        tick();
        t++;
        mem_req_ready = 1'b0;
        if (junk) begin
            if (exp_inst) i_miss_addr = 16'($urandom);
            else          d_miss_addr = 16'($urandom);
        end
        exp_line = '0;
        for (int b = 0; b < 8; b++) begin
            bub = (bmode == 1 && (b % 2) == 1) || (bmode == 2 && $urandom_range(0, 1) == 1);
            if (bub) begin
                mem_rsp_valid = 1'b0;
                mem_rsp_data  = 8'($urandom);
                tick();
                t++;
            end
            byt = rnd ? 8'($urandom) : base + 8'(b);
            exp_line[8*b +: 8] = byt;
            mem_rsp_valid = 1'b1;
            mem_rsp_data  = byt;
            tick();
            t++;
        end
        mem_rsp_valid = 1'b0;
        for (int w = 0; w < 4 && fill_we !== 1'b1; w++) begin
            tick();
            t++;
        end
        e = fill_entry;
        chk("fill_we", 128'(fill_we), 128'd1);
        chk("fill_is_inst", 128'(fill_is_inst), 128'(exp_inst));
        chk("i_ack", 128'(i_miss_ack), 128'(exp_inst));
        chk("d_ack", 128'(d_miss_ack), 128'(!exp_inst));
        chk("fill_way", 128'(fill_way), 128'(exp_way));
        chk("fill_index", 128'(fill_index), 128'(idx));
        chk("entry_valid", 128'(e.valid), 128'd1);
        chk("entry_tag", 128'(e.tag), 128'(tag));
        chk("entry_line", 128'(e.line), 128'(exp_line));
        chk("busy_write", 128'(busy), 128'd1);
        cap_way = fill_way;
        cap_idx = fill_index;
        cap_tag = e.tag;
        cap_req = mem_req_addr;
        if (exp_inst) mvic_i[idx] = !mvic_i[idx];
        else          mvic_d[idx] = !mvic_d[idx];
        mlast_inst = exp_inst;
        lat = t;
        if (exp_inst) i_miss_req = 1'b0;
        else          d_miss_req = 1'b0;
        tick();
        chk("fill_we_pulse", 128'(fill_we), 128'd0);
        chk("ack_pulse", 128'({i_miss_ack, d_miss_ack}), 128'd0);
        chk("busy_after", 128'(busy), 128'd0);
    endtask

    // Raises one or both requests in the same idle cycle and serves them in
    // the order the arbitration rule dictates.
    task automatic txn(input bit do_i, input bit do_d, input logic [15:0] ai,
                       input logic [15:0] ad, input int rdelay, input int bmode,
                       input bit junk, input bit rnd, input logic [7:0] base);
        int lat;
        bit first_inst;
        i_miss_addr = ai;
        d_miss_addr = ad;
        i_miss_req  = do_i;
        d_miss_req  = do_d;
        first_inst  = do_i && (!do_d || !mlast_inst);
        if (first_inst) serve(1'b1, ai, rdelay, bmode, junk, rnd, base, lat);
        else            serve(1'b0, ad, rdelay, bmode, junk, rnd, base, lat);
        if (do_i && do_d) begin
            if (first_inst) serve(1'b0, ad, rdelay, bmode, junk, rnd, base + 8'h08, lat);
            else            serve(1'b1, ai, rdelay, bmode, junk, rnd, base + 8'h08, lat);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int  lat;
        bit  ok;
        bit  m_i, m_d;
        logic [15:0] ai, ad;

        vecs[0] = '{1'b0, 16'h1A38, 8'h00, 1'b0, 6'h07, 7'h0D, 16'h1A38, 10};
        vecs[1] = '{1'b0, 16'h1A3F, 8'h20, 1'b1, 6'h07, 7'h0D, 16'h1A38, 10};
        vecs[2] = '{1'b0, 16'h5A38, 8'h40, 1'b0, 6'h07, 7'h2D, 16'h5A38, 10};
        vecs[3] = '{1'b1, 16'h1A38, 8'h60, 1'b0, 6'h07, 7'h0D, 16'h1A38, 10};
        vecs[4] = '{1'b1, 16'h0000, 8'h80, 1'b0, 6'h00, 7'h00, 16'h0000, 10};
        vecs[5] = '{1'b0, 16'hFFFF, 8'hA0, 1'b0, 6'h3F, 7'h7F, 16'hFFF8, 10};
        vecs[6] = '{1'b1, 16'h0038, 8'hC0, 1'b1, 6'h07, 7'h00, 16'h0038, 10};

        model_reset();
        repeat (3) tick();
        chk("rst_busy", 128'(busy), 128'd0);
        chk("rst_req_valid", 128'(mem_req_valid), 128'd0);
        chk("rst_req_addr", 128'(mem_req_addr), 128'd0);
        chk("rst_acks", 128'({i_miss_ack, d_miss_ack}), 128'd0);
        chk("rst_fill_we", 128'(fill_we), 128'd0);
        chk("rst_fill_meta", 128'({fill_is_inst, fill_way, fill_index}), 128'd0);
        chk("rst_fill_entry", 128'(fill_entry), 128'd0);
        rst_n = 1'b1;
        tick();

        // First tie: I wins because D counts as last serviced out of reset.
        txn(1'b1, 1'b1, 16'h0100, 16'h0208, 0, 0, 1'b0, 1'b0, 8'h10);

        // Directed table: victim toggling per side/set, tag/index split, latency.
        for (int v = 0; v < 7; v++) begin
            i_miss_addr = vecs[v].addr;
            d_miss_addr = vecs[v].addr;
            i_miss_req  = vecs[v].is_inst;
            d_miss_req  = !vecs[v].is_inst;
            serve(vecs[v].is_inst, vecs[v].addr, 0, 0, 1'b0, 1'b0, vecs[v].base, lat);
            chk($sformatf("tbl%0d_way", v), 128'(cap_way), 128'(vecs[v].exp_way));
            chk($sformatf("tbl%0d_idx", v), 128'(cap_idx), 128'(vecs[v].exp_idx));
            chk($sformatf("tbl%0d_tag", v), 128'(cap_tag), 128'(vecs[v].exp_tag));
            chk($sformatf("tbl%0d_req", v), 128'(cap_req), 128'(vecs[v].exp_req));
            chk($sformatf("tbl%0d_lat", v), 128'(lat), 128'(vecs[v].exp_lat));
        end

        // Second tie with I serviced last: D goes first.
        txn(1'b1, 1'b1, 16'h0900, 16'h0A08, 0, 0, 1'b0, 1'b0, 8'h20);

        // Slow request acceptance and a bubble before every odd beat.
        txn(1'b0, 1'b1, 16'h0000, 16'h3C20, 5, 1, 1'b0, 1'b0, 8'hA0);

        // Response noise in IDLE/REQ and address wiggle after accept.
        txn(1'b0, 1'b1, 16'h0000, 16'h4448, 2, 2, 1'b1, 1'b0, 8'h30);

        // Flip the D victim of set 2, then abort a refill of the same set.
        txn(1'b0, 1'b1, 16'h0000, 16'h2A10, 0, 0, 1'b0, 1'b0, 8'h70);
        d_miss_addr = 16'h2A10;
        d_miss_req  = 1'b1;
        ok = 1'b0;
        for (int w = 0; w < 20 && !ok; w++) begin
            tick();
            ok = (mem_req_valid === 1'b1);
        end
        chk("abort_req_seen", 128'(ok), 128'd1);
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        for (int b = 0; b < 4; b++) begin
            mem_rsp_valid = 1'b1;
            mem_rsp_data  = 8'hE0 + 8'(b);
            tick();
        end
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 8'hE4;
        #1 rst_n = 1'b0;
        #1;
        chk("abort_busy", 128'(busy), 128'd0);
        chk("abort_fill_we", 128'(fill_we), 128'd0);
        chk("abort_req_valid", 128'(mem_req_valid), 128'd0);
        chk("abort_entry", 128'(fill_entry), 128'd0);
        for (int w = 0; w < 2; w++) begin
            tick();
            chk("abort_hold_we", 128'(fill_we), 128'd0);
            chk("abort_hold_ack", 128'({i_miss_ack, d_miss_ack}), 128'd0);
        end
        d_miss_req    = 1'b0;
        mem_rsp_valid = 1'b0;
        rst_n         = 1'b1;
        tick();
        chk("abort_idle", 128'(busy), 128'd0);
        model_reset();
        txn(1'b0, 1'b1, 16'h0000, 16'h2A10, 0, 0, 1'b0, 1'b0, 8'h50);
        chk("abort_refill_way", 128'(cap_way), 128'd0);

        // Randomized traffic over a few sets so victims toggle often.
        for (int n = 0; n < 40; n++) begin
            m_i = 1'b0;
            m_d = 1'b0;
            case ($urandom_range(1, 3))
                1: m_i = 1'b1;
                2: m_d = 1'b1;
                default: begin m_i = 1'b1; m_d = 1'b1; end
            endcase
            ai = {7'($urandom), 6'($urandom_range(0, 3)), 3'($urandom)};
            ad = {7'($urandom), 6'($urandom_range(0, 3)), 3'($urandom)};
            txn(m_i, m_d, ai, ad, $urandom_range(0, 3), $urandom_range(0, 2), 1'b1, 1'b1, 8'h00);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
